// File: rtl/ahb_burst_master_if.sv
// rtl/ahb_burst_master_if.sv - command, write/read stream and AHB-Lite bus bundle for ahb_burst_master
interface ahb_burst_master_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16
);
  localparam int LEN_W = $clog2(MAX_BEATS) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, hrdata, hready, hresp,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done, error,
           haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, hrdata, hready, hresp,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done, error,
           haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite incrementing burst master with pipelined address/data phases
module ahb_burst_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  ahb_burst_master_if.master bus
);
  localparam int                LEN_W = $clog2(MAX_BEATS) + 1;
  localparam logic [2:0]        SIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W / 8);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {IDLE, ADDR, PIPE, LAST, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] haddr_q;
  logic [ADDR_W-1:0] haddr_inc;
  logic              hwrite_q;
  logic [2:0]        hburst_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              done_q;
  logic              error_q;
  logic [LEN_W-1:0]  beats_q;
  logic [LEN_W-1:0]  len_eff;
  logic              nseq_q;
  logic              first_q;
  logic [1:0]        htrans;
  logic              issue;
  logic              accept;
  logic              dp_active;
  logic              dp_done;
  logic              err_first;
  logic              last_beat;
  logic              wdata_ready;

  always_comb begin
    len_eff = bus.cmd_len;
    if (bus.cmd_len == '0)
      len_eff = LEN_W'(1);
    else if (bus.cmd_len > LEN_W'(MAX_BEATS))
      len_eff = LEN_W'(MAX_BEATS);
  end

  // A write beat may only present its address once its data word is on hand.
  assign issue       = ((state == ADDR) || (state == PIPE)) && (!hwrite_q || bus.wdata_valid);
  assign accept      = bus.cmd_valid && (state == IDLE);
  assign dp_active   = (state == PIPE) || ((state == LAST) && !done_q);
  assign dp_done     = dp_active && bus.hready;
  assign err_first   = dp_active && bus.hresp && !bus.hready;
  assign last_beat   = (beats_q == LEN_W'(1));
  assign haddr_inc   = haddr_q + STEP;
  assign wdata_ready = issue && bus.hready && hwrite_q;

  always_comb begin
    state_nxt = state;
    htrans    = TR_IDLE;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = ADDR;
      ADDR: begin
        if (issue) htrans = nseq_q ? TR_NONSEQ : TR_SEQ;
        else       htrans = first_q ? TR_IDLE : TR_BUSY;
        if (issue && bus.hready) state_nxt = last_beat ? LAST : PIPE;
      end
      PIPE: begin
        htrans = issue ? (nseq_q ? TR_NONSEQ : TR_SEQ) : TR_BUSY;
        if (err_first)
          state_nxt = ERR;
        else if (bus.hready)
          state_nxt = issue ? (last_beat ? LAST : PIPE) : ADDR;
      end
      // LAST and ERR linger one extra cycle for the DONE pulse so no command lands on it.
      LAST: begin
        if (done_q)         state_nxt = IDLE;
        else if (err_first) state_nxt = ERR;
      end
      ERR:     if (done_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state         <= IDLE;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hburst_q      <= 3'b000;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      beats_q       <= '0;
      nseq_q        <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      rdata_valid_q <= dp_done && !hwrite_q && !bus.hresp;
      if (dp_done && !hwrite_q && !bus.hresp)
        rdata_q <= bus.hrdata;
      done_q  <= !done_q && bus.hready && ((state == LAST) || (state == ERR));
      error_q <= !done_q && bus.hready && (state == ERR);
      if (wdata_ready)
        hwdata_q <= bus.wdata;
      if (accept) begin
        haddr_q  <= bus.cmd_addr;
        hwrite_q <= bus.cmd_write;
        hburst_q <= (len_eff == LEN_W'(1)) ? 3'b000 : 3'b001;
        beats_q  <= len_eff;
        nseq_q   <= 1'b1;
        first_q  <= 1'b1;
      end else if (issue && bus.hready) begin
        first_q <= 1'b0;
        beats_q <= beats_q - LEN_W'(1);
        if (!last_beat) begin
          haddr_q <= haddr_inc;
          // Crossing a 1 KB page restarts the burst with a NONSEQ beat.
          nseq_q  <= (haddr_inc[9:0] == 10'd0);
        end
      end
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.wdata_ready = wdata_ready;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.haddr       = haddr_q;
  assign bus.htrans      = htrans;
  assign bus.hwrite      = hwrite_q;
  assign bus.hsize       = SIZE;
  assign bus.hburst      = hburst_q;
  assign bus.hwdata      = hwdata_q;
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - table-driven bench with a slave model and scoreboard for ahb_burst_master
module tb_ahb_burst_master;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = 5;
  localparam logic [31:0] RD_KEY = 32'hC3A5_5A3C;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_burst_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) bus ();

  ahb_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(MAX_BEATS)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    int          len;
    int          wait_beat;
    int          wait_cyc;
    int          stall_idx;
    int          stall_cyc;
    int          err_beat;
    int          exp_busy;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
  } ap_t;

  vec_t        vecs [11];
  ap_t         exp_ap [$];
  logic [31:0] exp_rd [$];
  logic [31:0] exp_wd [$];
  logic [31:0] wbuf [0:255];

  int   n_chk = 0, n_pass = 0;
  int   ap_cnt, rd_cnt, wr_cnt, busy_cnt, widx;
  int   wait_beat, wait_left, stall_idx, stall_left, err_beat, err_phase;
  int   n_eff, n_iss, n_rd, n_wr;
  logic cur_wr = 1'b0;
  logic [2:0] cur_burst = 3'b000;
  logic dp_valid = 1'b0, dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  int   dp_num = 0;
  logic prev_hold = 1'b0, chk_idle_next = 1'b0, cmd_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [1:0]  prev_trans = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One bus cycle: drive slave/stream inputs at negedge, then check what the next posedge will see.
  task automatic tick();
    ap_t  e;
    logic ap_acc;
    logic hr;
    logic hp;
    @(negedge hclk);
    hr = 1'b1;
    hp = 1'b0;
    if (dp_valid && dp_num == err_beat) begin
      hp = 1'b1;
      hr = (err_phase != 0);
      err_phase = 1;
    end else if (dp_valid && dp_num == wait_beat && wait_left > 0) begin
      hr = 1'b0;
      wait_left--;
    end
    bus.hready    = hr;
    bus.hresp     = hp;
    bus.hrdata    = dp_valid ? (dp_addr ^ RD_KEY) : 32'h0BAD_F00D;
    bus.cmd_valid = cmd_pend;
    if (widx == stall_idx && stall_left > 0) begin
      bus.wdata_valid = 1'b0;
      stall_left--;
    end else begin
      bus.wdata_valid = 1'b1;
    end
    bus.wdata = wbuf[widx];
    #1;
    if (bus.rdata_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) chk("rdata_extra", 1, 0);
      else chk("rdata", bus.rdata, exp_rd.pop_front());
    end
    if (chk_idle_next) begin
      chk("err_htrans_idle", bus.htrans, 2'b00);
      chk_idle_next = 1'b0;
    end
    if (prev_hold) begin
      chk("hold_haddr", bus.haddr, prev_addr);
      chk("hold_htrans", bus.htrans, prev_trans);
    end
    if (bus.htrans == 2'b01) busy_cnt++;
    ap_acc = bus.htrans[1] && bus.hready;
    chk("wdata_ready", bus.wdata_ready, ap_acc && cur_wr);
    if (dp_valid && bus.hready) begin
      if (dp_write) begin
        if (exp_wd.size() == 0) chk("hwdata_missing", 0, 1);
        else chk("hwdata", bus.hwdata, exp_wd.pop_front());
      end else if (!bus.hresp) begin
        exp_rd.push_back(dp_addr ^ RD_KEY);
      end
      dp_valid = 1'b0;
    end
    if (dp_valid && bus.hresp && !bus.hready) chk_idle_next = 1'b1;
    prev_hold  = bus.htrans[1] && !bus.hready && !bus.hresp;
    prev_addr  = bus.haddr;
    prev_trans = bus.htrans;
    if (ap_acc) begin
      ap_cnt++;
      if (exp_ap.size() == 0) begin
        chk("ap_extra", 1, 0);
      end else begin
        e = exp_ap.pop_front();
        chk("haddr", bus.haddr, e.addr);
        chk("htrans", bus.htrans, e.trans);
      end
      chk("hwrite", bus.hwrite, cur_wr);
      chk("hburst", bus.hburst, cur_burst);
      chk("hsize", bus.hsize, 3'd2);
      dp_valid = 1'b1;
      dp_addr  = bus.haddr;
      dp_write = bus.hwrite;
      dp_num   = ap_cnt;
    end
    if (bus.wdata_ready) begin
      exp_wd.push_back(wbuf[widx]);
      widx++;
      wr_cnt++;
    end
    if (bus.cmd_valid && bus.cmd_ready) cmd_pend = 1'b0;
  endtask

  task automatic setup_cmd(input vec_t v);
    ap_t  e;
    logic err_hit;
    ap_cnt = 0; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; widx = 0;
    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    n_eff = (v.len == 0) ? 1 : ((v.len > MAX_BEATS) ? MAX_BEATS : v.len);
    err_hit = (v.err_beat != 0) && (v.err_beat <= n_eff);
    n_iss = err_hit ? v.err_beat : n_eff;
    n_rd  = v.wr ? 0 : (err_hit ? n_iss - 1 : n_eff);
    n_wr  = v.wr ? n_iss : 0;
    cur_wr    = v.wr;
    cur_burst = (n_eff == 1) ? 3'b000 : 3'b001;
    for (int i = 0; i < n_iss; i++) begin
      e.addr  = v.addr + 32'(4 * i);
      e.trans = (i == 0 || e.addr[9:0] == 10'd0) ? 2'b10 : 2'b11;
      exp_ap.push_back(e);
    end
    wait_beat  = v.wait_beat;  wait_left  = v.wait_cyc;
    stall_idx  = v.stall_idx;  stall_left = v.stall_cyc;
    err_beat   = v.err_beat;   err_phase  = 0;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = LEN_W'(v.len);
    cmd_pend      = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v);
    logic got_done;
    setup_cmd(v);
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      tick();
      if (bus.done) got_done = 1'b1;
    end
    chk("done_seen", got_done, 1);
    if (got_done) begin
      chk("error", bus.error, v.exp_err);
      chk("cmd_ready_in_done", bus.cmd_ready, 0);
    end
    tick();
    chk("cmd_ready_after", bus.cmd_ready, 1);
    chk("done_single", bus.done, 0);
    chk("beats", ap_cnt, n_iss);
    chk("rd_pulses", rd_cnt, n_rd);
    chk("wr_pulses", wr_cnt, n_wr);
    chk("busy_cycles", busy_cnt, v.exp_busy);
    chk("ap_left", exp_ap.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("wd_left", exp_wd.size(), 0);
    exp_ap.delete(); exp_rd.delete(); exp_wd.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_htrans"}, bus.htrans, 2'b00);
    chk({tag, "_haddr"}, bus.haddr, 0);
    chk({tag, "_hwrite"}, bus.hwrite, 0);
    chk({tag, "_hburst"}, bus.hburst, 3'b000);
    chk({tag, "_hsize"}, bus.hsize, 3'd2);
    chk({tag, "_hwdata"}, bus.hwdata, 0);
    chk({tag, "_wdata_ready"}, bus.wdata_ready, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_rdata_valid"}, bus.rdata_valid, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t mid;
    vec_t fresh;
    //           wr    addr       len wb wc si sc eb busy err
    vecs[0]  = '{1'b1, 32'h0100,   1, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0200,   4, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0300,   4, 2, 2, 2, 1, 0, 1, 1'b0};
    vecs[3]  = '{1'b0, 32'h03F8,   4, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0500,   8, 0, 0, 0, 0, 2, 0, 1'b1};
    vecs[5]  = '{1'b1, 32'h1000,   0, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[6]  = '{1'b0, 32'h2000,  31, 5, 3, 0, 0, 0, 0, 1'b0};
    vecs[7]  = '{1'b1, 32'h07F0,   8, 0, 0, 0, 0, 8, 0, 1'b1};
    vecs[8]  = '{1'b1, 32'h03FC,   2, 0, 0, 0, 0, 0, 0, 1'b0};
    vecs[9]  = '{1'b1, 32'h4000,  16, 3, 1, 0, 3, 0, 0, 1'b0};
    vecs[10] = '{1'b1, 32'h0600,   3, 0, 0, 1, 2, 0, 2, 1'b0};
    mid      = '{1'b1, 32'h0800,  16, 0, 0, 0, 0, 0, 0, 1'b0};
    fresh    = '{1'b0, 32'h0A00,   2, 0, 0, 0, 0, 0, 0, 1'b0};

    hresetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata = '0; bus.wdata_valid = 1'b0;
    bus.hrdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0;
    wait_beat = 0; wait_left = 0; stall_idx = 0; stall_left = 0; err_beat = 0; err_phase = 0;
    widx = 0; ap_cnt = 0; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 256; i++) wbuf[i] = '0;
    repeat (3) @(negedge hclk);
    #1;
    check_reset("rst");
    @(negedge hclk);
    hresetn = 1'b1;

    for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

    // Reset landing in the middle of a long write burst.
    setup_cmd(mid);
    for (int c = 0; c < 100 && ap_cnt < 3; c++) tick();
    chk("mid_reached_beat3", ap_cnt >= 3, 1);
    #1;
    hresetn = 1'b0;
    #1;
    check_reset("mid_rst");
    cmd_pend = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge hclk);
      #1;
      chk("mid_rst_no_done", bus.done, 0);
      chk("mid_rst_htrans", bus.htrans, 2'b00);
    end
    exp_ap.delete(); exp_rd.delete(); exp_wd.delete();
    dp_valid = 1'b0; prev_hold = 1'b0; chk_idle_next = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    run_cmd(fresh);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 Parameter DATA_W, default 32, meaning HWDATA/HRDATA/WDATA/RDATA width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, meaning HADDR/CMD_ADDR width.
REQ-003 Parameter MAX_BEATS, default 16, meaning the largest burst length accepted (power of 2, 2..256); LEN_W = clog2(MAX_BEATS)+1.
REQ-004 HCLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 HRESETn  in  1  asynchronous active-low reset; release is synchronous to HCLK.
REQ-006 CMD_VALID/CMD_READY  in/out  1/1  command handshake; a command is accepted when both are 1.
REQ-007 CMD_WRITE, CMD_ADDR, CMD_LEN  in  1/ADDR_W/LEN_W  direction, word-aligned start address, beat count 1..MAX_BEATS.
REQ-008 WDATA, WDATA_VALID / WDATA_READY  in/out  DATA_W,1 / 1  write-beat stream, one word per handshake.
REQ-009 RDATA, RDATA_VALID  out  DATA_W,1  read-beat stream; there is no backpressure.
REQ-010 DONE, ERROR  out  1,1  single-cycle completion pulse; ERROR is high in the DONE cycle when the burst was aborted.
REQ-011 HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA  out  ADDR_W,2,1,3,3,DATA_W  AHB-Lite master outputs.
REQ-012 HRDATA, HREADY, HRESP  in  DATA_W,1,1  AHB-Lite slave response.

Function
REQ-013 States SHALL be IDLE, ADDR (address phase, no data phase pending), PIPE (address phase of beat k+1 overlapped with data phase of beat k), LAST (final data phase only) and ERR (abort cycle).
REQ-014 CMD_READY SHALL equal (state==IDLE); on acceptance the block latches the command and enters ADDR.
REQ-015 HTRANS SHALL be NONSEQ (10) for the first beat, SEQ (11) for later beats, BUSY (01) while a write beat is stalled, and IDLE (00) in IDLE, LAST and ERR.
REQ-016 HBURST SHALL be SINGLE (000) when CMD_LEN==1 and INCR (001) otherwise; HSIZE SHALL equal clog2(DATA_W/8).
REQ-017 Address and control SHALL advance only on a cycle with HREADY=1; HADDR increments by DATA_W/8 per beat.
REQ-018 When an increment crosses a 1 KB boundary (HADDR[9:0] wraps to 0), that beat SHALL be issued as NONSEQ.
REQ-019 A write beat's address phase SHALL be issued only when WDATA_VALID=1. Otherwise HTRANS=BUSY with the address held; the first beat waits in ADDR with HTRANS=IDLE.
REQ-020 WDATA_READY SHALL be 1 in the cycle in which a write beat's address phase completes (HREADY=1); WDATA is then registered into HWDATA and held through that beat's data phase.
REQ-021 RDATA_VALID SHALL pulse with RDATA=HRDATA on each read data phase that completes with HREADY=1 and HRESP=0.
REQ-022 After the last address phase completes, the block SHALL enter LAST. DONE pulses in the cycle after the final data phase completes, and the block returns to IDLE with CMD_READY=1.
REQ-023 A new command SHALL NOT be accepted in the same cycle that DONE pulses; minimum command-to-command spacing is one IDLE cycle.
REQ-024 On HRESP=1 with HREADY=0 (first error cycle), the block SHALL drive HTRANS=IDLE in the next cycle and enter ERR.
REQ-025 In ERR the block SHALL discard remaining beats, pulse DONE with ERROR=1 after the second error cycle (HREADY=1), and return to IDLE.
REQ-026 A beat counter SHALL count down from CMD_LEN; the block SHALL treat CMD_LEN=0 as 1 and clamp CMD_LEN>MAX_BEATS to MAX_BEATS.

Reset
REQ-027 While HRESETn=0, outputs SHALL be: HTRANS=00, HADDR=0, HWRITE=0, HBURST=000, HSIZE per REQ-016, HWDATA=0, WDATA_READY=0, RDATA=0, RDATA_VALID=0, DONE=0, ERROR=0, CMD_READY=1. State SHALL be IDLE.
REQ-028 Reset asserted mid-burst SHALL abandon the burst immediately, with no DONE pulse; the first command after release is accepted normally.

Verification
REQ-029 Single write, LEN=1, ADDR=0x100, HREADY=1 -> HTRANS 10 for one cycle, HBURST=000, HWDATA=WDATA next cycle, DONE pulse, ERROR=0.
REQ-030 Read INCR LEN=4, ADDR=0x200, DATA_W=32 -> HADDR 0x200/204/208/20C, HTRANS 10,11,11,11, exactly 4 RDATA_VALID pulses, DONE pulse.
REQ-031 Write LEN=4 with HREADY=0 for 2 cycles on beat 2 and WDATA_VALID=0 for 1 cycle before beat 3 -> address held under wait, HTRANS=01 during the stall, 4 WDATA_READY pulses, correct HWDATA order.
REQ-032 Read LEN=4 from ADDR=0x3F8 -> beat at 0x400 issued as NONSEQ, the other beats SEQ.
REQ-033 Error response (HRESP=1, HREADY=0 then 1) on beat 2 of 8 -> HTRANS=00 next cycle, no further beats, DONE and ERROR=1 together, CMD_READY=1 afterwards.
REQ-034 HRESETn=0 during beat 3 of a 16-beat write -> all outputs at REQ-027 values asynchronously, and a fresh command completes after release.
